pifo_reader: RTL
================

PIFO_READER -- requirements
Module: pifo_reader

Interface
REQ-001 The block SHALL have parameter MAX_PRIORITY, default 256, priority range; PRIO_WIDTH = $clog2(MAX_PRIORITY).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, payload width.
REQ-003 The block SHALL have parameter POP_GAP, default 0, minimum idle cycles between consecutive PIFO pops (range 0..255).
REQ-004 The block SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-low reset (reset==0 resets).
REQ-006 The block SHALL have port i__pifo_valid  input  1  PIFO head valid (non-empty).
REQ-007 The block SHALL have port i__pifo_priority  input  PRIO_WIDTH  PIFO head priority.
REQ-008 The block SHALL have port i__pifo_data  input  DATA_WIDTH  PIFO head payload.
REQ-009 The block SHALL have port o__pifo_ready  output  1  dequeue request to PIFO.
REQ-010 The block SHALL have port i__pifo_push  input  1  PIFO enqueue accepted this cycle (valid & ready on PIFO input side).
REQ-011 The block SHALL have port i__flush  input  1  discard all buffered entries.
REQ-012 The block SHALL have port o__data_out_valid  output  1  downstream entry available.
REQ-013 The block SHALL have port o__data_out_priority  output  PRIO_WIDTH  downstream priority.
REQ-014 The block SHALL have port o__data_out  output  DATA_WIDTH  downstream payload.
REQ-015 The block SHALL have port i__data_out_ready  input  1  downstream accepts entry.

Function
REQ-016 Pop SHALL occur when i__pifo_valid & o__pifo_ready; entry captured into a 2-entry in-order output buffer at that edge.
REQ-017 o__pifo_ready SHALL be: reset==1 & ~i__flush & ~i__pifo_push & (occupancy<2) & (state==READY); never depends on i__data_out_ready.
REQ-018 o__pifo_ready SHALL be low whenever i__pifo_push is high, so push and pop never coincide at the PIFO.
REQ-019 FSM states SHALL be READY and GAP; READY->GAP on pop when POP_GAP>0, gap counter loaded with POP_GAP; GAP decrements each cycle, GAP->READY when counter reaches 1; POP_GAP=0 stays in READY.
REQ-020 Pop-to-output latency SHALL be 1 cycle: entry popped at edge N visible on o__data_out* from edge N onward when buffer was empty.
REQ-021 o__data_out_valid SHALL equal occupancy!=0; outputs SHALL present the oldest buffered entry.
REQ-022 Downstream transfer SHALL occur on o__data_out_valid & i__data_out_ready; occupancy decrements.
REQ-023 Simultaneous pop and downstream transfer SHALL keep occupancy unchanged and preserve order.
REQ-024 With occupancy 2, no pop SHALL occur; after one downstream transfer, o__pifo_ready may assert next cycle.
REQ-025 With POP_GAP=0 and continuous downstream ready, pops SHALL sustain one per cycle.
REQ-026 Buffered entries SHALL NOT be reordered by later higher-priority pushes; inversion bounded by 2 entries.
REQ-027 i__flush SHALL clear occupancy and gap counter at the next edge, force READY, and block any pop that cycle; downstream transfer that cycle is ignored.
REQ-028 Occupancy SHALL be 2 bits; it SHALL never exceed 2 nor underflow.

Reset
REQ-029 On reset==0 at a clock edge: occupancy=0, state=READY, gap counter=0, buffer data/priority=0.
REQ-030 During reset, o__pifo_ready=0 combinationally, o__data_out_valid=0, o__data_out=0, o__data_out_priority=0.
REQ-031 Reset asserted mid-operation SHALL drop all buffered entries; no pop SHALL occur in a reset cycle.

Configuration
REQ-032 With macro PIFO_READER_STATS_EN defined, port o__pop_count (output, 16 bits) SHALL count accepted pops, saturate at 16'hFFFF, clear on reset only (not flush).
REQ-033 Without PIFO_READER_STATS_EN, o__pop_count and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-034 Reset then PIFO heads prio 200,150,90 valid, downstream ready, POP_GAP=0 -> outputs 200,150,90 on consecutive cycles, o__pifo_ready high 3 cycles.
REQ-035 i__pifo_push high with head valid -> o__pifo_ready low that cycle, pop deferred to next cycle with push low.
REQ-036 Downstream ready low, 4 valid heads -> exactly 2 pops, o__pifo_ready low; ready high one cycle -> one transfer, one further pop.
REQ-037 POP_GAP=2, head always valid, downstream ready -> pops spaced 3 cycles apart (pop, idle, idle, pop).
REQ-038 Occupancy 2 then i__flush -> next cycle o__data_out_valid=0, no pop in flush cycle; o__pop_count (STATS_EN) unchanged.
REQ-039 STATS_EN, 70000 pops -> o__pop_count=16'hFFFF; reset==0 -> o__pop_count=0.

Source files
------------

// File: rtl/pifo_reader.sv
// PIFO head reader: pops the PIFO head into a 2-entry in-order output buffer with optional
// inter-pop gap. Define PIFO_READER_STATS_EN to add the saturating o__pop_count output.
module pifo_reader #(
  parameter int unsigned MAX_PRIORITY = 256,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned POP_GAP      = 0,
  localparam int unsigned PRIO_WIDTH  = $clog2(MAX_PRIORITY)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i__pifo_valid,
  input  logic [PRIO_WIDTH-1:0] i__pifo_priority,
  input  logic [DATA_WIDTH-1:0] i__pifo_data,
  output logic                  o__pifo_ready,
  input  logic                  i__pifo_push,
  input  logic                  i__flush,
  output logic                  o__data_out_valid,
  output logic [PRIO_WIDTH-1:0] o__data_out_priority,
  output logic [DATA_WIDTH-1:0] o__data_out,
  input  logic                  i__data_out_ready
`ifdef PIFO_READER_STATS_EN
  ,
  output logic [15:0]           o__pop_count
`endif
);

  typedef enum logic {StReady, StGap} state_e;

  localparam logic [7:0] GapLoad = 8'(POP_GAP);

  state_e                state_q, state_d;
  logic [7:0]            gap_cnt_q, gap_cnt_d;
  logic [1:0]            occ_q, occ_d;
  logic [PRIO_WIDTH-1:0] prio0_q, prio0_d, prio1_q, prio1_d;
  logic [DATA_WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
  logic                  pop, xfer;
  logic [1:0]            slot;

  assign o__pifo_ready = reset & ~i__flush & ~i__pifo_push & (occ_q < 2'd2) & (state_q == StReady);
  assign pop           = i__pifo_valid & o__pifo_ready;
  assign xfer          = reset & ~i__flush & (occ_q != 2'd0) & i__data_out_ready;

  // Outputs are forced to zero while reset is held, independent of the registers.
  assign o__data_out_valid    = reset & (occ_q != 2'd0);
  assign o__data_out_priority = reset ? prio0_q : '0;
  assign o__data_out          = reset ? data0_q : '0;

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    occ_d     = occ_q + {1'b0, pop} - {1'b0, xfer};
    prio0_d   = prio0_q;
    prio1_d   = prio1_q;
    data0_d   = data0_q;
    data1_d   = data1_q;
    slot      = occ_q - {1'b0, xfer};

    if (xfer) begin
      prio0_d = prio1_q;
      data0_d = data1_q;
    end
    // New entry lands behind whatever remains after this cycle's transfer.
    if (pop) begin
      if (slot == 2'd0) begin
        prio0_d = i__pifo_priority;
        data0_d = i__pifo_data;
      end else begin
        prio1_d = i__pifo_priority;
        data1_d = i__pifo_data;
      end
    end

    unique case (state_q)
      StReady: begin
        if (pop && (GapLoad != 8'd0)) begin
          state_d   = StGap;
          gap_cnt_d = GapLoad;
        end
      end
      StGap: begin
        if (gap_cnt_q <= 8'd1) begin
          state_d   = StReady;
          gap_cnt_d = 8'd0;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: state_d = StReady;
    endcase

    if (i__flush) begin
      occ_d     = 2'd0;
      gap_cnt_d = 8'd0;
      state_d   = StReady;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StReady;
      gap_cnt_q <= 8'd0;
      occ_q     <= 2'd0;
      prio0_q   <= '0;
      prio1_q   <= '0;
      data0_q   <= '0;
      data1_q   <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      occ_q     <= occ_d;
      prio0_q   <= prio0_d;
      prio1_q   <= prio1_d;
      data0_q   <= data0_d;
      data1_q   <= data1_d;
    end
  end

`ifdef PIFO_READER_STATS_EN
  logic [15:0] pop_count_q, pop_count_d;

  // Flush deliberately leaves the count alone; only reset clears it.
  always_comb begin
    pop_count_d = pop_count_q;
    if (pop && (pop_count_q != 16'hFFFF)) pop_count_d = pop_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) pop_count_q <= 16'd0;
    else        pop_count_q <= pop_count_d;
  end

  assign o__pop_count = pop_count_q;
`endif

endmodule
